// File: rtl/prime_collector.sv
// prime_collector: gathers primes from the primenums result stream into an in-order first-word-fall-through FIFO.
// Latency: a prime recognised in cycle N is readable (RdValid/RdData) in cycle N+1; there is no same-cycle bypass.
// Backpressure: RdReady stalls the read side. A prime arriving at a full FIFO with no same-cycle pop is dropped and sets Overflow.
//
// Ports: SysClk/Reset (async, active-low) | NumMax, NumberChecked, Prime, NumberofPrimesFound from/alongside upstream
//        RdValid/RdReady/RdData read port | PrimeTotal, Done, Overflow, CountMatch, MaxGap status.
// Optional feature: define PRIME_GAP_TRACK_EN to build the largest-prime-gap tracker; otherwise MaxGap reads 0.
module prime_collector #(
    parameter int W     = 10,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic         SysClk,
    input  logic         Reset,
    input  logic [W-1:0] NumMax,
    input  logic [W-1:0] NumberChecked,
    input  logic         Prime,
    input  logic [7:0]   NumberofPrimesFound,
    input  logic         RdReady,
    output logic         RdValid,
    output logic [W-1:0] RdData,
    output logic [7:0]   PrimeTotal,
    output logic         Done,
    output logic         Overflow,
    output logic         CountMatch,
    output logic [W-1:0] MaxGap
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  last_num;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [W-1:0]  mem [DEPTH];

    logic recog;
    logic prime_seen;
    logic full;
    logic pop;
    logic push;

    // A value counts once however long upstream holds it; LastNum starting at 0
    // means the idle upstream value 0 after reset is never taken as a result.
    assign recog      = !Done && (NumberChecked != last_num);
    assign prime_seen = recog && Prime;
    assign full       = (count == FULL_CNT);
    assign pop        = RdValid && RdReady;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
    assign push       = prime_seen && (!full || pop);

    assign RdValid    = (count != '0);
    assign RdData     = mem[rptr];
    assign CountMatch = Done && (PrimeTotal == NumberofPrimesFound);

    // Storage is deliberately not reset; RdValid gates its visibility.
    always_ff @(posedge SysClk) begin
        if (push) begin
            mem[wptr] <= NumberChecked;
        end
    end

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            last_num   <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            PrimeTotal <= '0;
            Done       <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            if (recog) begin
                last_num <= NumberChecked;
                if (NumberChecked >= NumMax) begin
                    Done <= 1'b1;
                end
            end
            if (prime_seen) begin
                if (PrimeTotal != 8'hFF) begin
                    PrimeTotal <= PrimeTotal + 8'd1;
                end
                if (!push) begin
                    Overflow <= 1'b1;
                end
            end
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PRIME_GAP_TRACK_EN
    logic [W-1:0] last_prime;
    logic [W-1:0] gap;

    assign gap = NumberChecked - last_prime;

    // Gap tracking follows every recognised prime, including ones the FIFO drops.
    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            last_prime <= '0;
            MaxGap     <= '0;
        end else if (prime_seen) begin
            if ((last_prime != '0) && (gap > MaxGap)) begin
                MaxGap <= gap;
            end
            last_prime <= NumberChecked;
        end
    end
`else
    assign MaxGap = '0;
`endif

endmodule
